// File: rtl/arctangent_search.sv
// rtl/arctangent_search.sv - binary-search arctangent over a tangent_LUT (0..MAX_ANGLE degrees)
// Optional feature macro: ATAN_EARLY_EXIT_EN (finish as soon as a probe matches exactly).
module arctangent_search #(
    parameter int DATA_WIDTH  = 32,
    parameter int LUT_LATENCY = 1,
    parameter int MAX_ANGLE   = 90
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] tan_in,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   angle_out,
    output logic [1:0]              quadrant_out,
    output logic                    error,
    output logic                    lut_en_tangent,
    output logic [1:0]              lut_quadrant,
    output logic [DATA_WIDTH-1:0]   lut_data_in,
    input  logic [2*DATA_WIDTH-1:0] lut_data_out
);
    localparam int TW     = 2 * DATA_WIDTH;
    localparam int MANT_W = TW - 12;
    localparam int ITERS  = 7;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [TW-2:0]           mag;
    logic                    sign, is_nan, is_inf;
    logic [DATA_WIDTH-1:0]   lo, hi, lo_cmp, hi_cmp;
    logic [2:0]              iter;
    logic [7:0]              wait_cnt;
    logic                    in_nan, in_inf, accept, lut_le, lut_eq;
    logic                    lut_en_d, done_d;
    logic [DATA_WIDTH-1:0]   lut_din_d;
    logic                    unused_sign_bit;

    function automatic logic [DATA_WIDTH-1:0] midpoint(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b} + (DATA_WIDTH+1)'(1);
        return s[DATA_WIDTH:1];
    endfunction

    assign in_nan = (&tan_in[TW-2 -: 11]) && (|tan_in[MANT_W-1:0]);
    assign in_inf = (&tan_in[TW-2 -: 11]) && !(|tan_in[MANT_W-1:0]);
    assign accept = (state == S_IDLE) && start;
    assign lut_quadrant = 2'b00;
    assign unused_sign_bit = lut_data_out[TW-1];

    // Non-negative doubles order the same way as their raw bit patterns.
    assign lut_le = lut_data_out[TW-2:0] <= mag;
    assign lut_eq = lut_data_out[TW-2:0] == mag;

    always_comb begin
        lo_cmp = lo;
        hi_cmp = hi;
        if (lut_le) lo_cmp = lut_data_in;
        else        hi_cmp = lut_data_in - DATA_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (is_nan || is_inf) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == 8'(LUT_LATENCY - 1)) state_nxt = S_CMP;
            S_CMP: begin
`ifdef ATAN_EARLY_EXIT_EN
                if (lut_eq || iter == 3'(ITERS - 1)) state_nxt = S_DONE;
                else                                 state_nxt = S_ISSUE;
`else
                if (iter == 3'(ITERS - 1)) state_nxt = S_DONE;
                else                       state_nxt = S_ISSUE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobe and probe values are registered so the LUT sees clean inputs for all of ISSUE/WAIT.
    always_comb begin
        lut_en_d  = 1'b0;
        lut_din_d = lut_data_in;
        done_d    = (state == S_DONE);
        if (accept) begin
            lut_en_d = !(in_nan || in_inf);
            if (!(in_nan || in_inf)) lut_din_d = midpoint('0, DATA_WIDTH'(MAX_ANGLE));
        end else if (state == S_CMP && state_nxt == S_ISSUE) begin
            lut_en_d  = 1'b1;
            lut_din_d = midpoint(lo_cmp, hi_cmp);
        end else if (state_nxt == S_WAIT || (state == S_WAIT && state_nxt == S_WAIT)) begin
            lut_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            angle_out      <= '0;
            quadrant_out   <= 2'b00;
            error          <= 1'b0;
            lut_en_tangent <= 1'b0;
            lut_data_in    <= '0;
            mag            <= '0;
            sign           <= 1'b0;
            is_nan         <= 1'b0;
            is_inf         <= 1'b0;
            lo             <= '0;
            hi             <= '0;
            iter           <= '0;
            wait_cnt       <= '0;
        end else begin
            lut_en_tangent <= lut_en_d;
            lut_data_in    <= lut_din_d;
            done           <= done_d;
            if (accept) begin
                mag    <= tan_in[TW-2:0];
                sign   <= tan_in[TW-1];
                is_nan <= in_nan;
                is_inf <= in_inf;
                lo     <= '0;
                hi     <= DATA_WIDTH'(MAX_ANGLE);
                iter   <= '0;
                busy   <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
            if (state == S_CMP) begin
                lo   <= lo_cmp;
                hi   <= hi_cmp;
                iter <= iter + 3'd1;
            end
            if (state == S_DONE) begin
                angle_out    <= is_nan ? '0 : (is_inf ? DATA_WIDTH'(MAX_ANGLE) : lo);
                quadrant_out <= {1'b0, sign};
                error        <= is_nan;
            end
        end
    end
endmodule

// File: tb/tb_arctangent_search.sv
// tb/tb_arctangent_search.sv - directed self-checking bench for arctangent_search with a tangent_LUT model
module tb_arctangent_search;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [63:0] tan_in;
    logic        busy, done, error, lut_en_tangent;
    logic [31:0] angle_out, lut_data_in;
    logic [1:0]  quadrant_out, lut_quadrant;
    logic [63:0] lut_data_out = 64'h0;
    logic [63:0] lut_tab [0:90];

    int tests  = 0;
    int failed = 0;

`ifdef ATAN_EARLY_EXIT_EN
    localparam int NLAT   = -1;
    localparam int ONELAT = 4;
`else
    localparam int NLAT   = 22;
    localparam int ONELAT = 22;
`endif

    always #5 clk = ~clk;

    arctangent_search dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tan_in(tan_in),
        .busy(busy), .done(done), .angle_out(angle_out), .quadrant_out(quadrant_out),
        .error(error), .lut_en_tangent(lut_en_tangent), .lut_quadrant(lut_quadrant),
        .lut_data_in(lut_data_in), .lut_data_out(lut_data_out)
    );

    // tangent_LUT stand-in with one cycle of latency
    always_ff @(posedge clk) begin
        if (lut_en_tangent) begin
            if (lut_data_in <= 32'd90) lut_data_out <= lut_tab[lut_data_in[6:0]];
            else                       lut_data_out <= 64'h7FF0000000000000;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [63:0] x, input int exp_angle,
                       input int exp_quad, input int exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        tan_in = x;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_accept"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_angle"}, 64'(angle_out), 64'(exp_angle));
        check({tag, "_quad"}, 64'(quadrant_out), 64'(exp_quad));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_with_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_angle_held"}, 64'(angle_out), 64'(exp_angle));
    endtask

    initial begin
        int pulses;
        int first;
        reset_n = 1'b0;
        start   = 1'b0;
        tan_in  = 64'h0;
        for (int a = 0; a <= 90; a++)
            lut_tab[a] = $realtobits($tan(real'(a) * 3.14159265358979323846 / 180.0));
        lut_tab[0]  = 64'h0;
        lut_tab[45] = 64'h3FF0000000000000;
        lut_tab[90] = 64'h7FF0000000000000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_angle", 64'(angle_out), 64'd0);
        check("rst_quad", 64'(quadrant_out), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_lut_en", 64'(lut_en_tangent), 64'd0);
        check("rst_lut_din", 64'(lut_data_in), 64'd0);
        check("lut_quadrant", 64'(lut_quadrant), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run("one",      64'h3FF0000000000000, 45, 0, 0, ONELAT);
        run("neg_one",  64'hBFF0000000000000, 45, 1, 0, NLAT);
        run("p625",     64'h3FE4000000000000, 32, 0, 0, NLAT);
        run("zero",     64'h0000000000000000, 0,  0, 0, NLAT);
        run("neg_zero", 64'h8000000000000000, 0,  1, 0, NLAT);
        run("denorm",   64'h0000000000000001, 0,  0, 0, NLAT);
        run("big",      64'h4202A05F20000000, 89, 0, 0, NLAT);
        run("nan",      64'h7FF8000000000000, 0,  0, 1, 2);
        run("pinf",     64'h7FF0000000000000, 90, 0, 0, 2);
        run("ninf",     64'hFFF0000000000000, 90, 1, 0, 2);
        check("lut_quadrant_after", 64'(lut_quadrant), 64'd0);

        // second start mid-search must be ignored
        @(negedge clk);
        tan_in = 64'h3FE4000000000000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                tan_in = 64'h3FF0000000000000;
                start  = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i == 5) start = 1'b0;
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    check("restart_angle", 64'(angle_out), 64'd32);
                end
            end
        end
        check("restart_pulses", 64'(pulses), 64'd1);
        if (NLAT >= 0) check("restart_latency", 64'(first), 64'(NLAT));
        check("restart_idle_busy", 64'(busy), 64'd0);

        // reset in the middle of a search
        @(negedge clk);
        tan_in = 64'h3FF0000000000000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_angle", 64'(angle_out), 64'd0);
        check("midrst_quad", 64'(quadrant_out), 64'd0);
        check("midrst_lut_en", 64'(lut_en_tangent), 64'd0);
        check("midrst_lut_din", 64'(lut_data_in), 64'd0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run("after_rst", 64'h3FE4000000000000, 32, 0, 0, NLAT);

        for (int a = 0; a < 90; a++)
            run($sformatf("sweep_%0d", a), lut_tab[a], a, 0, 0, NLAT);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
